program_loader: RTL and testbench
=================================

Name: program_loader

Overview:
- Write-side counterpart of the BIP program memory.
- Receives a byte stream from the UART receiver and frames it as a word count followed by instruction words.
- Assembles each instruction word and drives the program memory write port sequentially from address 0.
- Holds the CPU disabled until loading completes, then releases it.

Parameters:
- RAM_WIDTH, 16, instruction word width; must be a multiple of 8; BYTES = RAM_WIDTH/8.
- RAM_DEPTH, 2048, number of program memory entries; maximum loadable word count.
- ADDR_WIDTH, 11, write address width; must equal clogb2(RAM_DEPTH-1).

Ports:
- i_clk, input, 1, clock; all logic on rising edge.
- i_rst, input, 1, asynchronous active-high reset.
- i_rx_data, input, 8, received byte.
- i_rx_valid, input, 1, byte valid.
- o_rx_ready, output, 1, loader can accept a byte.
- i_reload, input, 1, single-cycle pulse; restarts loading from DONE or ERROR.
- o_wr_addr, output, ADDR_WIDTH, program memory write address.
- o_wr_data, output, RAM_WIDTH, program memory write data.
- o_wr_en, output, 1, program memory write strobe, one cycle per word.
- o_cpu_enb, output, 1, CPU run enable.
- o_done, output, 1, load complete.
- o_error, output, 1, count exceeded RAM_DEPTH.

Behaviour:
- Byte acceptance: a byte transfers on a rising edge with i_rx_valid=1 and o_rx_ready=1. Bytes presented while o_rx_ready=0 are ignored (dropped, no state change).
- Reset (asynchronous, any state, including mid-load): state CNT_HI, o_rx_ready=1, o_wr_en=0, o_wr_addr=0, o_wr_data=0, o_cpu_enb=0, o_done=0, o_error=0. Internal count, byte counter and word counter are cleared.
- o_rx_ready=1 only in CNT_HI, CNT_LO and DATA.
- CNT_HI: on accept, count[15:8] <= byte; go to CNT_LO.
- CNT_LO: on accept, count[7:0] <= byte, then:
  - assembled count == 0 -> DONE;
  - assembled count > RAM_DEPTH -> ERROR;
  - otherwise -> DATA, with byte index and word counter cleared.
- DATA: each accepted byte shifts into the word register MSB-first (first byte lands in bits [RAM_WIDTH-1 -: 8]). On the BYTES-th byte, go to WRITE.
- WRITE: exactly one cycle.
  - o_wr_en=1; o_wr_data = assembled word; o_wr_addr = word index.
  - Next cycle: o_wr_en=0 and o_wr_addr increments.
  - If the words written now equal count -> DONE, else -> DATA.
- Write addressing: o_wr_addr and o_wr_data are registered outputs, stable during the o_wr_en cycle. Write latency from accepting the last byte of a word to o_wr_en is 1 cycle.
- Address limit: o_wr_addr never wraps. A count of RAM_DEPTH writes addresses 0..RAM_DEPTH-1, and the increment after the last write is not used.
- DONE: o_done=1 and o_cpu_enb=1, held. On i_reload: return to CNT_HI, o_done=0, o_cpu_enb=0, o_wr_addr=0.
- ERROR: o_error=1, o_cpu_enb=0, held. On i_reload: return to CNT_HI with all counters cleared.
- i_reload in CNT_HI, CNT_LO, DATA or WRITE is ignored. Reset is the only abort for a load in progress.
- Simultaneous i_rx_valid and i_reload in DONE or ERROR: the reload wins and the byte is not accepted (o_rx_ready=0 in that cycle).
- Width rule: the count comparison uses 17-bit arithmetic against RAM_DEPTH, so RAM_DEPTH=2048 with count 0x0800 is accepted and 0x0801 is rejected.

Test Plan:
- Reset then bytes 00 02 12 34 AB CD -> o_wr_en pulses twice: addr 0 data 0x1234, then addr 1 data 0xABCD; o_done=1 and o_cpu_enb=1 one cycle after the second write.
- Header 00 00 -> DONE directly, no o_wr_en pulse, o_cpu_enb=1.
- Header 08 01 (2049 words) -> o_error=1, o_cpu_enb=0, o_rx_ready=0; i_reload then restores CNT_HI with o_rx_ready=1.
- Header 08 00 followed by 2048 words with data equal to address -> last write at addr 0x7FF data 0x07FF, no address wrap, then DONE.
- Assert i_rst after header 00 03 and one data word -> all outputs return to reset values immediately (asynchronously); a fresh 00 01 5A5A then writes addr 0 data 0x5A5A.
- Hold i_rx_valid=1 continuously with byte 0x11 after header 00 01 -> byte dropped during the WRITE cycle; exactly one write of 0x1111; DONE; in DONE further bytes are ignored and the state is unchanged.

Source files
------------

// File: rtl/program_loader.sv
// Frames a UART byte stream (16-bit word count, then MSB-first words) into
// sequential program-memory writes from address 0; the CPU is enabled once loading is done.
module program_loader #(
  parameter int RAM_WIDTH  = 16,
  parameter int RAM_DEPTH  = 2048,
  parameter int ADDR_WIDTH = 11
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [7:0]            i_rx_data,
  input  logic                  i_rx_valid,
  output logic                  o_rx_ready,
  input  logic                  i_reload,
  output logic [ADDR_WIDTH-1:0] o_wr_addr,
  output logic [RAM_WIDTH-1:0]  o_wr_data,
  output logic                  o_wr_en,
  output logic                  o_cpu_enb,
  output logic                  o_done,
  output logic                  o_error
);

  localparam int BYTES = RAM_WIDTH / 8;
  localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [16:0] DEPTH_17 = 17'(RAM_DEPTH);

  typedef enum logic [2:0] {
    ST_CNT_HI = 3'd0,
    ST_CNT_LO = 3'd1,
    ST_DATA   = 3'd2,
    ST_WRITE  = 3'd3,
    ST_DONE   = 3'd4,
    ST_ERROR  = 3'd5
  } state_t;

  state_t                state_r, state_s;
  logic [15:0]           count_r;
  logic [IDX_W-1:0]      byte_idx_r;
  logic [ADDR_WIDTH:0]   word_cnt_r;
  logic [RAM_WIDTH-1:0]  word_r;
  logic [ADDR_WIDTH-1:0] wr_addr_r;
  logic [RAM_WIDTH-1:0]  wr_data_r;
  logic                  wr_en_r;
  logic                  ready_r;
  logic                  done_r;
  logic                  error_r;

  logic                  accept_s;
  logic                  last_byte_s;
  logic                  last_word_s;
  logic [15:0]           count_full_s;
  logic [RAM_WIDTH-1:0]  word_s;

  // A word count of 17 bits keeps the comparison against RAM_DEPTH exact.
  assign accept_s     = i_rx_valid & ready_r;
  assign last_byte_s  = (byte_idx_r == IDX_W'(BYTES - 1));
  assign last_word_s  = ((17'(word_cnt_r) + 17'd1) == {1'b0, count_r});
  assign count_full_s = {count_r[15:8], i_rx_data};
  assign word_s       = (word_r << 4'd8) | RAM_WIDTH'(i_rx_data);

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_CNT_HI: begin
        if (accept_s) state_s = ST_CNT_LO;
        else          state_s = ST_CNT_HI;
      end
      ST_CNT_LO: begin
        if (!accept_s)                            state_s = ST_CNT_LO;
        else if (count_full_s == 16'd0)           state_s = ST_DONE;
        else if ({1'b0, count_full_s} > DEPTH_17) state_s = ST_ERROR;
        else                                      state_s = ST_DATA;
      end
      ST_DATA: begin
        if (accept_s && last_byte_s) state_s = ST_WRITE;
        else                         state_s = ST_DATA;
      end
      ST_WRITE: begin
        if (last_word_s) state_s = ST_DONE;
        else             state_s = ST_DATA;
      end
      ST_DONE: begin
        if (i_reload) state_s = ST_CNT_HI;
        else          state_s = ST_DONE;
      end
      ST_ERROR: begin
        if (i_reload) state_s = ST_CNT_HI;
        else          state_s = ST_ERROR;
      end
      default: state_s = ST_CNT_HI;
    endcase
  end

  // State register and status flags, registered from the next state.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r <= ST_CNT_HI;
      ready_r <= 1'b1;
      wr_en_r <= 1'b0;
      done_r  <= 1'b0;
      error_r <= 1'b0;
    end else begin
      state_r <= state_s;
      ready_r <= (state_s == ST_CNT_HI) || (state_s == ST_CNT_LO) || (state_s == ST_DATA);
      wr_en_r <= (state_s == ST_WRITE);
      done_r  <= (state_s == ST_DONE);
      error_r <= (state_s == ST_ERROR);
    end
  end

  // Count capture, word assembly and write addressing.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      count_r    <= 16'd0;
      byte_idx_r <= '0;
      word_cnt_r <= '0;
      word_r     <= '0;
      wr_addr_r  <= '0;
      wr_data_r  <= '0;
    end else begin
      case (state_r)
        ST_CNT_HI: begin
          if (accept_s) count_r[15:8] <= i_rx_data;
        end
        ST_CNT_LO: begin
          if (accept_s) begin
            count_r[7:0] <= i_rx_data;
            byte_idx_r   <= '0;
            word_cnt_r   <= '0;
            wr_addr_r    <= '0;
          end
        end
        ST_DATA: begin
          if (accept_s) begin
            word_r <= word_s;
            if (last_byte_s) begin
              wr_data_r  <= word_s;
              byte_idx_r <= '0;
            end else begin
              byte_idx_r <= byte_idx_r + 1'b1;
            end
          end
        end
        ST_WRITE: begin
          word_cnt_r <= word_cnt_r + 1'b1;
          // Address stays on the final word so a full-depth load never wraps to 0.
          if (!last_word_s) wr_addr_r <= wr_addr_r + 1'b1;
        end
        ST_DONE, ST_ERROR: begin
          if (i_reload) begin
            count_r    <= 16'd0;
            byte_idx_r <= '0;
            word_cnt_r <= '0;
            wr_addr_r  <= '0;
          end
        end
        default: begin
          count_r <= count_r;
        end
      endcase
    end
  end

  assign o_rx_ready = ready_r;
  assign o_wr_addr  = wr_addr_r;
  assign o_wr_data  = wr_data_r;
  assign o_wr_en    = wr_en_r;
  assign o_cpu_enb  = done_r;
  assign o_done     = done_r;
  assign o_error    = error_r;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: header vector table, directed corner
// sequences and randomized loads compared against a word-list reference model.
module tb_program_loader;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [7:0]  i_rx_data;
  logic        i_rx_valid;
  logic        o_rx_ready;
  logic        i_reload;
  logic [10:0] o_wr_addr;
  logic [15:0] o_wr_data;
  logic        o_wr_en;
  logic        o_cpu_enb;
  logic        o_done;
  logic        o_error;

  program_loader dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_rx_data  (i_rx_data),
    .i_rx_valid (i_rx_valid),
    .o_rx_ready (o_rx_ready),
    .i_reload   (i_reload),
    .o_wr_addr  (o_wr_addr),
    .o_wr_data  (o_wr_data),
    .o_wr_en    (o_wr_en),
    .o_cpu_enb  (o_cpu_enb),
    .o_done     (o_done),
    .o_error    (o_error)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [7:0] hi;
    logic [7:0] lo;
    logic       ready;
    logic       done;
    logic       error;
  } hdr_vec_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  bit          gaps     = 1'b0;
  logic [26:0] got_q[$];
  logic [26:0] exp_q[$];
  hdr_vec_t    vecs[6];

  // Write monitor: every strobed word is recorded as {addr, data}.
  always @(negedge i_clk) begin
    if (!i_rst && o_wr_en) got_q.push_back({o_wr_addr, o_wr_data});
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic apply_reset();
    i_rst = 1'b1;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge i_clk);
    if (gaps) repeat ($urandom_range(0, 2)) @(negedge i_clk);
    i_rx_data  = b;
    i_rx_valid = 1'b1;
    i_reload   = gaps && ($urandom_range(0, 3) == 0);
    while (!o_rx_ready && n < 100) begin
      @(negedge i_clk);
      n++;
    end
    if (n >= 100) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: ready never rose for byte %h", b);
    end
    @(posedge i_clk);
    #1;
    i_rx_valid = 1'b0;
    i_reload   = 1'b0;
  endtask

  task automatic send_load(input logic [15:0] cnt, input logic [15:0] w[$]);
    send_byte(cnt[15:8]);
    send_byte(cnt[7:0]);
    foreach (w[i]) begin
      send_byte(w[i][15:8]);
      send_byte(w[i][7:0]);
    end
  endtask

  task automatic wait_end();
    int n;
    n = 0;
    while (!(o_done || o_error) && n < 200) begin
      @(negedge i_clk);
      n++;
    end
    if (n >= 200) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_end: no done/error within %0d cycles", n);
    end
    @(negedge i_clk);
  endtask

  task automatic pulse_reload();
    @(negedge i_clk);
    i_reload = 1'b1;
    @(posedge i_clk);
    #1;
    i_reload = 1'b0;
  endtask

  task automatic compare_writes(input string name);
    int n;
    chk({name, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk({name, "_word"}, 32'(got_q[i]), 32'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [15:0] words[$];
    logic [15:0] cnt;
    int          kind;

    i_rst = 1'b1; i_rx_data = 8'h00; i_rx_valid = 1'b0; i_reload = 1'b0;
    vecs[0] = '{hi: 8'h00, lo: 8'h00, ready: 1'b0, done: 1'b1, error: 1'b0};
    vecs[1] = '{hi: 8'h08, lo: 8'h01, ready: 1'b0, done: 1'b0, error: 1'b1};
    vecs[2] = '{hi: 8'h08, lo: 8'h00, ready: 1'b1, done: 1'b0, error: 1'b0};
    vecs[3] = '{hi: 8'hFF, lo: 8'hFF, ready: 1'b0, done: 1'b0, error: 1'b1};
    vecs[4] = '{hi: 8'h00, lo: 8'h05, ready: 1'b1, done: 1'b0, error: 1'b0};
    vecs[5] = '{hi: 8'h10, lo: 8'h00, ready: 1'b0, done: 1'b0, error: 1'b1};

    // Reset state
    @(negedge i_clk);
    chk("rst_ready", 32'(o_rx_ready), 32'(1'b1));
    chk("rst_wr_en", 32'(o_wr_en), 32'(1'b0));
    chk("rst_addr",  32'(o_wr_addr), 32'(11'd0));
    chk("rst_data",  32'(o_wr_data), 32'(16'd0));
    chk("rst_cpu",   32'(o_cpu_enb), 32'(1'b0));
    chk("rst_done",  32'(o_done), 32'(1'b0));
    chk("rst_error", 32'(o_error), 32'(1'b0));
    apply_reset();

    // Two-word load with exact write timing, then reload racing a byte
    send_byte(8'h00); send_byte(8'h02); send_byte(8'h12); send_byte(8'h34);
    send_byte(8'hAB); send_byte(8'hCD);
    @(negedge i_clk);
    chk("t1_wr_en",  32'(o_wr_en), 32'(1'b1));
    chk("t1_addr",   32'(o_wr_addr), 32'(11'd1));
    chk("t1_data",   32'(o_wr_data), 32'(16'hABCD));
    chk("t1_early",  32'(o_done), 32'(1'b0));
    @(negedge i_clk);
    chk("t1_wr_off", 32'(o_wr_en), 32'(1'b0));
    chk("t1_done",   32'(o_done), 32'(1'b1));
    chk("t1_cpu",    32'(o_cpu_enb), 32'(1'b1));
    exp_q.push_back({11'd0, 16'h1234});
    exp_q.push_back({11'd1, 16'hABCD});
    compare_writes("t1");
    @(negedge i_clk);
    i_rx_data = 8'h00; i_rx_valid = 1'b1; i_reload = 1'b1;
    chk("race_ready", 32'(o_rx_ready), 32'(1'b0));
    @(posedge i_clk);
    #1;
    i_rx_valid = 1'b0; i_reload = 1'b0;
    @(negedge i_clk);
    chk("reload_ready", 32'(o_rx_ready), 32'(1'b1));
    chk("reload_done",  32'(o_done), 32'(1'b0));
    chk("reload_cpu",   32'(o_cpu_enb), 32'(1'b0));
    chk("reload_addr",  32'(o_wr_addr), 32'(11'd0));
    words = {16'hABCD};
    send_load(16'd1, words);
    wait_end();
    chk("race_done", 32'(o_done), 32'(1'b1));
    exp_q.push_back({11'd0, 16'hABCD});
    compare_writes("race");

    // Header table
    foreach (vecs[v]) begin
      apply_reset();
      send_byte(vecs[v].hi);
      send_byte(vecs[v].lo);
      @(negedge i_clk);
      chk("hdr_ready", 32'(o_rx_ready), 32'(vecs[v].ready));
      chk("hdr_done",  32'(o_done), 32'(vecs[v].done));
      chk("hdr_error", 32'(o_error), 32'(vecs[v].error));
      chk("hdr_cpu",   32'(o_cpu_enb), 32'(vecs[v].done));
      compare_writes("hdr");
      if (vecs[v].error) begin
        pulse_reload();
        @(negedge i_clk);
        chk("err_reload_ready", 32'(o_rx_ready), 32'(1'b1));
        chk("err_reload_error", 32'(o_error), 32'(1'b0));
      end
    end

    // Asynchronous reset in the middle of a load
    apply_reset();
    send_byte(8'h00); send_byte(8'h03); send_byte(8'h12); send_byte(8'h34);
    @(negedge i_clk);
    @(negedge i_clk);
    chk("mid_addr_pre", 32'(o_wr_addr), 32'(11'd1));
    #2 i_rst = 1'b1;
    #1;
    chk("arst_ready", 32'(o_rx_ready), 32'(1'b1));
    chk("arst_addr",  32'(o_wr_addr), 32'(11'd0));
    chk("arst_data",  32'(o_wr_data), 32'(16'd0));
    chk("arst_wr_en", 32'(o_wr_en), 32'(1'b0));
    chk("arst_flags", 32'({o_cpu_enb, o_done, o_error}), 32'(3'b000));
    got_q.delete();
    @(negedge i_clk);
    i_rst = 1'b0;
    words = {16'h5A5A};
    send_load(16'd1, words);
    wait_end();
    chk("arst_done", 32'(o_done), 32'(1'b1));
    exp_q.push_back({11'd0, 16'h5A5A});
    compare_writes("arst");

    // Continuously held valid: byte dropped in WRITE, ignored in DONE
    apply_reset();
    send_byte(8'h00); send_byte(8'h01);
    @(negedge i_clk);
    i_rx_data = 8'h11; i_rx_valid = 1'b1;
    repeat (8) @(negedge i_clk);
    chk("hold_done",  32'(o_done), 32'(1'b1));
    chk("hold_ready", 32'(o_rx_ready), 32'(1'b0));
    i_rx_valid = 1'b0;
    exp_q.push_back({11'd0, 16'h1111});
    compare_writes("hold");
    repeat (3) @(negedge i_clk);
    chk("hold_stays_done", 32'(o_done), 32'(1'b1));
    compare_writes("hold_after");

    // Full-depth load: data equals address, last write at 0x7FF
    apply_reset();
    words.delete();
    for (int i = 0; i < 2048; i++) begin
      words.push_back(16'(i));
      exp_q.push_back({11'(i), 16'(i)});
    end
    send_load(16'h0800, words);
    wait_end();
    chk("full_done",  32'(o_done), 32'(1'b1));
    chk("full_error", 32'(o_error), 32'(1'b0));
    compare_writes("full");

    // Randomized loads against the word-list model
    apply_reset();
    gaps = 1'b1;
    for (int it = 0; it < 25; it++) begin
      kind = $urandom_range(0, 9);
      words.delete();
      if (kind == 0)      cnt = 16'd0;
      else if (kind == 1) cnt = 16'($urandom_range(2049, 65535));
      else                cnt = 16'($urandom_range(1, 6));
      if (cnt <= 16'd2048) begin
        for (int i = 0; i < int'(cnt); i++) begin
          words.push_back(16'($urandom()));
          exp_q.push_back({11'(i), words[i]});
        end
      end
      send_load(cnt, words);
      wait_end();
      chk("rnd_done",  32'(o_done), 32'(cnt <= 16'd2048));
      chk("rnd_error", 32'(o_error), 32'(cnt > 16'd2048));
      chk("rnd_cpu",   32'(o_cpu_enb), 32'(cnt <= 16'd2048));
      compare_writes("rnd");
      pulse_reload();
      @(negedge i_clk);
      chk("rnd_reload_ready", 32'(o_rx_ready), 32'(1'b1));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
